// File: rtl/sum_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sum_seq_ctrl
//  Description : Pushbutton-driven sequencer for an external 4-bit ripple
//                adder. The raw active-low button is synchronized and
//                debounced. Each accepted press steps the sequence
//                A-load -> B-load -> capture -> show.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DB_CNT_W      width of the debounce counter
//    DB_LIMIT      consecutive stable cycles before a button level is accepted
//  Ports
//    clk           system clock, rising edge
//    rst_n         asynchronous active-low reset
//    btn_n         raw active-low pushbutton (asynchronous)
//    sw_data[3:0]  switch operand value
//    sw_cin        switch carry-in value
//    sum_in[3:0]   sum from the external adder
//    co_in         carry-out from the external adder
//    ain[3:0]      operand A to the adder
//    bin[3:0]      operand B to the adder
//    ci            carry-in to the adder
//    result[4:0]   captured {co_in, sum_in}
//    result_valid  high while result holds a completed addition
//    state[1:0]    current sequencer state
// ============================================================================
module sum_seq_ctrl #(
  parameter int DB_CNT_W = 16,
  parameter int DB_LIMIT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic [3:0] sw_data,
  input  logic       sw_cin,
  input  logic [3:0] sum_in,
  input  logic       co_in,
  output logic [3:0] ain,
  output logic [3:0] bin,
  output logic       ci,
  output logic [4:0] result,
  output logic       result_valid,
  output logic [1:0] state
);

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_CALC = 2'b10;
  localparam logic [1:0] S_SHOW = 2'b11;

  localparam logic [DB_CNT_W-1:0] c_db_max = DB_CNT_W'(DB_LIMIT - 1);
  localparam logic [DB_CNT_W-1:0] c_db_one = DB_CNT_W'(1);

  // --------------------------------------------------------------------------
  // Button synchronizer and debouncer
  // --------------------------------------------------------------------------
  logic                r_sync1;
  logic                r_sync2;
  logic                r_db_level;
  logic [DB_CNT_W-1:0] r_db_cnt;
  logic                r_press;

  logic w_differ;
  logic w_accept;

  assign w_differ = (r_sync2 != r_db_level);
  assign w_accept = w_differ && (r_db_cnt == c_db_max);

  // Idle level is released (1) so a button held through reset still has
  // to be debounced before it counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      // The pulse is registered at the same edge the level flips, so it is
      // high for exactly the one cycle following the accepted 1->0 change.
      r_press <= w_accept && !r_sync2;
      if (w_accept) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else if (w_differ) begin
        r_db_cnt <= r_db_cnt + c_db_one;
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [3:0] r_ain;
  logic [3:0] r_bin;
  logic       r_ci;
  logic [4:0] r_result;
  logic       r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_A;
      r_ain    <= '0;
      r_bin    <= '0;
      r_ci     <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          if (r_press) begin
            r_ain   <= sw_data;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (r_press) begin
            r_bin   <= sw_data;
            r_ci    <= sw_cin;
            r_state <= S_CALC;
          end
        end
        // One cycle with the operands settled at the adder; a press here is
        // deliberately not looked at.
        S_CALC: begin
          r_result <= {co_in, sum_in};
          r_valid  <= 1'b1;
          r_state  <= S_SHOW;
        end
        // A press here starts a new addition; the old result stays visible
        // (but flagged invalid) until the next capture.
        S_SHOW: begin
          if (r_press) begin
            r_valid <= 1'b0;
            r_ain   <= sw_data;
            r_state <= S_B;
          end
        end
        default: begin
          r_state <= S_A;
        end
      endcase
    end
  end

  assign ain          = r_ain;
  assign bin          = r_bin;
  assign ci           = r_ci;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sum_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_seq_ctrl
//  Description : Self-checking bench for sum_seq_ctrl with DB_LIMIT=4. The
//                external adder is modelled with plain arithmetic. Directed
//                table vectors, hand-written multi-cycle sequences, and
//                random press/glitch operations against a transaction-level
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_seq_ctrl;

  localparam int DB_LIMIT = 4;
  localparam int HOLD     = DB_LIMIT + 5;
  localparam int REL      = DB_LIMIT + 6;

  logic       clk;
  logic       rst_n;
  logic       btn_n;
  logic [3:0] sw_data;
  logic       sw_cin;
  logic [3:0] sum_in;
  logic       co_in;
  logic [3:0] ain;
  logic [3:0] bin;
  logic       ci;
  logic [4:0] result;
  logic       result_valid;
  logic [1:0] state;

  logic [4:0] w_add;

  int n_total;
  int n_pass;

  sum_seq_ctrl #(
    .DB_CNT_W (16),
    .DB_LIMIT (DB_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .sw_data      (sw_data),
    .sw_cin       (sw_cin),
    .sum_in       (sum_in),
    .co_in        (co_in),
    .ain          (ain),
    .bin          (bin),
    .ci           (ci),
    .result       (result),
    .result_valid (result_valid),
    .state        (state)
  );

  // Downstream ripple adder
  assign w_add  = 5'(ain) + 5'(bin) + 5'(ci);
  assign sum_in = w_add[3:0];
  assign co_in  = w_add[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 = full press, 1 = short glitch (3 cycles)
    logic [3:0] sw;
    logic       cin;
    logic [1:0] e_state;
    logic [3:0] e_ain;
    logic [3:0] e_bin;
    logic       e_ci;
    logic [4:0] e_res;
    logic       e_v;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_state,
                           input logic [3:0] e_ain, input logic [3:0] e_bin,
                           input logic e_ci, input logic [4:0] e_res,
                           input logic e_v);
    check({tag, ".state"}, int'(state), int'(e_state));
    check({tag, ".ain"}, int'(ain), int'(e_ain));
    check({tag, ".bin"}, int'(bin), int'(e_bin));
    check({tag, ".ci"}, int'(ci), int'(e_ci));
    check({tag, ".result"}, int'(result), int'(e_res));
    check({tag, ".valid"}, int'(result_valid), int'(e_v));
  endtask

  // Full press: operands are set before the button falls and scrambled once
  // it is released, which must not disturb anything already loaded.
  task automatic press(input logic [3:0] sw, input logic cin);
    @(negedge clk);
    sw_data = sw;
    sw_cin  = cin;
    btn_n   = 1'b0;
    repeat (HOLD) @(negedge clk);
    btn_n   = 1'b1;
    sw_data = 4'($urandom);
    sw_cin  = 1'($urandom);
    repeat (REL) @(negedge clk);
  endtask

  task automatic glitch(input int len, input logic [3:0] sw);
    @(negedge clk);
    sw_data = sw;
    btn_n   = 1'b0;
    repeat (len) @(negedge clk);
    btn_n = 1'b1;
    repeat (REL) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Transaction-level reference model
  int         m_phase;   // 0 = waiting for A, 1 = waiting for B, 3 = showing
  logic [3:0] m_a, m_b;
  logic       m_ci, m_v;
  logic [4:0] m_res;

  task automatic model_press(input logic [3:0] sw, input logic cin);
    case (m_phase)
      0: begin m_a = sw; m_phase = 1; end
      1: begin
        m_b = sw; m_ci = cin;
        m_res = 5'(m_a) + 5'(m_b) + 5'(m_ci);
        m_v = 1'b1; m_phase = 3;
      end
      default: begin m_v = 1'b0; m_a = sw; m_phase = 1; end
    endcase
  endtask

  initial begin
    bit found;
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    btn_n   = 1'b1;
    sw_data = 4'h0;
    sw_cin  = 1'b0;

    //               kind sw    cin  st     ain    bin    ci  res    v
    tbl[0] = '{1, 4'h7, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 5'h00, 1'b0};
    tbl[1] = '{0, 4'h9, 1'b0, 2'b01, 4'h9, 4'h0, 1'b0, 5'h00, 1'b0};
    tbl[2] = '{0, 4'h8, 1'b0, 2'b11, 4'h9, 4'h8, 1'b0, 5'h11, 1'b1};
    tbl[3] = '{0, 4'h3, 1'b1, 2'b01, 4'h3, 4'h8, 1'b0, 5'h11, 1'b0};
    tbl[4] = '{1, 4'h6, 1'b0, 2'b01, 4'h3, 4'h8, 1'b0, 5'h11, 1'b0};
    tbl[5] = '{0, 4'hF, 1'b1, 2'b11, 4'h3, 4'hF, 1'b1, 5'h13, 1'b1};
    tbl[6] = '{0, 4'h0, 1'b0, 2'b01, 4'h0, 4'hF, 1'b1, 5'h13, 1'b0};
    tbl[7] = '{0, 4'h0, 1'b0, 2'b11, 4'h0, 4'h0, 1'b0, 5'h00, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check_all("reset", 2'b00, 4'h0, 4'h0, 1'b0, 5'h00, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].kind == 1) glitch(3, tbl[i].sw);
      else press(tbl[i].sw, tbl[i].cin);
      check_all($sformatf("tbl%0d", i), tbl[i].e_state, tbl[i].e_ain,
                tbl[i].e_bin, tbl[i].e_ci, tbl[i].e_res, tbl[i].e_v);
    end

    // Capture timing: B-load -> one CALC cycle -> SHOW with valid
    press(4'h2, 1'b0);
    check("lat.state_b", int'(state), 1);
    @(negedge clk);
    sw_data = 4'h4;
    sw_cin  = 1'b1;
    btn_n   = 1'b0;
    found   = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clk); #1;
      if (state == 2'b10) found = 1'b1;
    end
    check("lat.reach_calc", int'(found), 1);
    check("lat.calc_valid", int'(result_valid), 0);
    @(posedge clk); #1;
    check("lat.show_state", int'(state), 3);
    check("lat.show_valid", int'(result_valid), 1);
    check("lat.result", int'(result), 5'h07);
    @(negedge clk);
    btn_n = 1'b1;
    repeat (REL) @(negedge clk);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 2'b00, 4'h0, 4'h0, 1'b0, 5'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Long hold gives exactly one press
    sw_data = 4'h6;
    btn_n   = 1'b0;
    repeat (100) @(negedge clk);
    check("hold.state", int'(state), 1);
    check("hold.ain", int'(ain), 6);
    btn_n = 1'b1;
    repeat (20) @(negedge clk);
    check("hold.release_state", int'(state), 1);

    // Reset in S_B abandons the operation
    do_reset();
    press(4'h5, 1'b0);
    check("midrst.loaded", int'(ain), 5);
    rst_n = 1'b0;
    #1;
    check("midrst.state", int'(state), 0);
    check("midrst.ain", int'(ain), 0);
    @(negedge clk);
    rst_n = 1'b1;
    press(4'hA, 1'b0);
    check("midrst.fresh_state", int'(state), 1);
    check("midrst.fresh_ain", int'(ain), 10);

    // Button already low when reset releases
    @(negedge clk);
    rst_n   = 1'b0;
    btn_n   = 1'b0;
    sw_data = 4'hC;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DB_LIMIT + 2) @(posedge clk);
    #1;
    check("rstlow.before", int'(state), 0);
    @(posedge clk); #1;
    check("rstlow.after", int'(state), 1);
    check("rstlow.ain", int'(ain), 12);
    @(negedge clk);
    btn_n = 1'b1;
    repeat (REL) @(negedge clk);

    // Random operations against the reference model
    do_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_ci = 1'b0; m_res = '0; m_v = 1'b0;
    for (int k = 0; k < 30; k++) begin
      logic [3:0] rsw;
      logic       rcin;
      rsw  = 4'($urandom);
      rcin = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        glitch(int'($urandom_range(1, 3)), rsw);
      end else begin
        press(rsw, rcin);
        model_press(rsw, rcin);
      end
      check_all($sformatf("rnd%0d", k), 2'(m_phase), m_a, m_b, m_ci, m_res, m_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
